// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator.
//   Divides the system clock down to a pixel tick, walks x/y across the
//   configured line/frame geometry and produces registered sync, blanking,
//   coordinate and strobe outputs. A run/stop FSM only stops at a frame
//   boundary so downstream logic never sees a truncated frame.
// Ports:
//   clk_100MHz   system clock
//   reset        asynchronous active-high reset
//   en           run request (level)
//   p_tick       one-clk pixel tick
//   video_on     x/y inside the visible area
//   hsync/vsync  sync outputs, active level HSYNC_POL / VSYNC_POL
//   x, y         current pixel coordinates
//   line_start   one-clk strobe, x just became 0
//   frame_start  one-clk strobe, (x,y) just became (0,0)
//   vblank_tick  one-clk strobe, first pixel of line V_DISPLAY
//   frame_count  completed frames (wraps)
//   running      high in RUN or DRAIN
module vga_timing_gen #(
  parameter int   CLK_DIV   = 4,
  parameter int   H_DISPLAY = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_DISPLAY = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   CW        = 11,
  parameter int   FRAME_W   = 16
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               en,
  output logic               p_tick,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic [CW-1:0]      x,
  output logic [CW-1:0]      y,
  output logic               line_start,
  output logic               frame_start,
  output logic               vblank_tick,
  output logic [FRAME_W-1:0] frame_count,
  output logic               running
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  localparam logic [CW-1:0] HMAX  = CW'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CW-1:0] VMAX  = CW'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CW-1:0] HD    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] VD    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_LO = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_HI = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_LO = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_HI = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [DW-1:0]   div, div_n;
  logic [CW-1:0]   x_n, y_n;
  logic            adv, end_line, end_frame, active_n, start;

  // Next-state values; outputs are registered from these so that sync and
  // video_on always line up with the x/y visible in the same cycle.
  always_comb begin
    adv       = p_tick;
    end_line  = (x == HMAX);
    end_frame = end_line && (y == VMAX);

    x_n = x;
    y_n = y;
    if (adv) begin
      if (end_line) begin
        x_n = '0;
        y_n = (y == VMAX) ? '0 : y + 1'b1;
      end else begin
        x_n = x + 1'b1;
      end
    end

    state_n = state;
    case (state)
      IDLE:    if (en) state_n = RUN;
      RUN:     if (!en) state_n = DRAIN;
      DRAIN:   if (en) state_n = RUN;
               else if (adv && end_frame) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    active_n = (state_n != IDLE);
    start    = (state == IDLE) && (state_n == RUN);

    // Divider is frozen at 0 on the entry edge and whenever stopping, so the
    // first RUN cycle always sits at phase 0.
    if (state == IDLE || state_n == IDLE) div_n = '0;
    else if (div == DIV_MAX)              div_n = '0;
    else                                  div_n = div + 1'b1;
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      div         <= '0;
      x           <= '0;
      y           <= '0;
      p_tick      <= 1'b0;
      video_on    <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblank_tick <= 1'b0;
      frame_count <= '0;
      running     <= 1'b0;
    end else begin
      state       <= state_n;
      div         <= div_n;
      x           <= x_n;
      y           <= y_n;
      running     <= active_n;
      p_tick      <= active_n && (div_n == DIV_MAX);
      video_on    <= active_n && (x_n < HD) && (y_n < VD);
      hsync       <= (active_n && x_n >= HS_LO && x_n <= HS_HI) ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= (active_n && y_n >= VS_LO && y_n <= VS_HI) ? VSYNC_POL : ~VSYNC_POL;
      // Counters already rest at (0,0) in IDLE, so entry pulses both strobes.
      line_start  <= start || (adv && end_line);
      frame_start <= start || (adv && end_frame);
      vblank_tick <= adv && end_line && (y_n == VD);
      if (adv && end_frame) frame_count <= frame_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: CLK_DIV=2, H 4/1/2/1 (HMAX=7), V 3/1/1/1 (VMAX=5), active-low syncs
  logic        rst_a, en_a;
  logic        a_pt, a_von, a_hs, a_vs, a_ls, a_fs, a_vb, a_run;
  logic [10:0] a_x, a_y;
  logic [15:0] a_fc;

  // DUT B: same geometry, CLK_DIV=1, active-high syncs
  logic        rst_b, en_b;
  logic        b_pt, b_von, b_hs, b_vs, b_ls, b_fs, b_vb, b_run;
  logic [10:0] b_x, b_y;
  logic [15:0] b_fc;

  vga_timing_gen #(
    .CLK_DIV(2), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(11), .FRAME_W(16)
  ) dut_a (
    .clk_100MHz(clk), .reset(rst_a), .en(en_a),
    .p_tick(a_pt), .video_on(a_von), .hsync(a_hs), .vsync(a_vs),
    .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs),
    .vblank_tick(a_vb), .frame_count(a_fc), .running(a_run)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(11), .FRAME_W(16)
  ) dut_b (
    .clk_100MHz(clk), .reset(rst_b), .en(en_b),
    .p_tick(b_pt), .video_on(b_von), .hsync(b_hs), .vsync(b_vs),
    .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs),
    .vblank_tick(b_vb), .frame_count(b_fc), .running(b_run)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n = cycles since the first RUN cycle; pixel index advances every 2 clks.
  task automatic check_a(input int n, input int fc_base);
    int p, xe, ye;
    p  = n / 2;
    xe = p % 8;
    ye = (p / 8) % 6;
    chk("a_x",      32'(a_x),   32'(xe));
    chk("a_y",      32'(a_y),   32'(ye));
    chk("a_p_tick", 32'(a_pt),  32'(n % 2));
    chk("a_hsync",  32'(a_hs),  (xe == 5 || xe == 6) ? 32'd0 : 32'd1);
    chk("a_vsync",  32'(a_vs),  (ye == 4) ? 32'd0 : 32'd1);
    chk("a_video",  32'(a_von), (xe < 4 && ye < 3) ? 32'd1 : 32'd0);
    chk("a_line",   32'(a_ls),  (n % 16 == 0) ? 32'd1 : 32'd0);
    chk("a_frame",  32'(a_fs),  (n % 96 == 0) ? 32'd1 : 32'd0);
    chk("a_vblank", 32'(a_vb),  (n % 96 == 48) ? 32'd1 : 32'd0);
    chk("a_fcount", 32'(a_fc),  32'(fc_base + n / 96));
    chk("a_run",    32'(a_run), 32'd1);
  endtask

  task automatic check_b(input int n);
    int xe, ye;
    xe = n % 8;
    ye = (n / 8) % 6;
    chk("b_x",      32'(b_x),   32'(xe));
    chk("b_y",      32'(b_y),   32'(ye));
    chk("b_p_tick", 32'(b_pt),  32'd1);
    chk("b_hsync",  32'(b_hs),  (xe == 5 || xe == 6) ? 32'd1 : 32'd0);
    chk("b_vsync",  32'(b_vs),  (ye == 4) ? 32'd1 : 32'd0);
    chk("b_video",  32'(b_von), (xe < 4 && ye < 3) ? 32'd1 : 32'd0);
    chk("b_line",   32'(b_ls),  (n % 8 == 0) ? 32'd1 : 32'd0);
    chk("b_frame",  32'(b_fs),  (n % 48 == 0) ? 32'd1 : 32'd0);
    chk("b_vblank", 32'(b_vb),  (n % 48 == 24) ? 32'd1 : 32'd0);
    chk("b_fcount", 32'(b_fc),  32'(n / 48));
  endtask

  task automatic check_a_idle(input string tag, input int fc);
    chk({tag, "_x"},      32'(a_x),   32'd0);
    chk({tag, "_y"},      32'(a_y),   32'd0);
    chk({tag, "_p_tick"}, 32'(a_pt),  32'd0);
    chk({tag, "_hsync"},  32'(a_hs),  32'd1);
    chk({tag, "_vsync"},  32'(a_vs),  32'd1);
    chk({tag, "_video"},  32'(a_von), 32'd0);
    chk({tag, "_run"},    32'(a_run), 32'd0);
    chk({tag, "_fcount"}, 32'(a_fc),  32'(fc));
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0;
    repeat (3) step();

    // Reset state of A
    check_a_idle("rst", 0);
    chk("rst_line",   32'(a_ls), 32'd0);
    chk("rst_frame",  32'(a_fs), 32'd0);
    chk("rst_vblank", 32'(a_vb), 32'd0);

    // Run three frames plus part of a fourth; drop en at (x=2,y=1) of frame 4
    rst_a = 1'b0;
    en_a  = 1'b1;
    for (int n = 0; n < 384; n++) begin
      step();
      check_a(n, 0);
      if (n == 288) chk("three_frames", 32'(a_fc), 32'd3);
      if (n == 308) begin
        chk("drop_x", 32'(a_x), 32'd2);
        chk("drop_y", 32'(a_y), 32'd1);
        en_a = 1'b0;
      end
    end

    // Drain completes on the wrap: back to IDLE with the frame counted
    step();
    check_a_idle("drained", 4);
    step();
    check_a_idle("idle_hold", 4);

    // Restart; drop and re-raise en mid-frame: no gap, frame completes normally
    en_a = 1'b1;
    for (int n = 0; n <= 106; n++) begin
      step();
      check_a(n, 4);
      if (n == 20) en_a = 1'b0;
      if (n == 30) en_a = 1'b1;
    end

    // Asynchronous reset mid-line at x=5
    chk("pre_rst_x", 32'(a_x), 32'd5);
    #2 rst_a = 1'b1;
    #1;
    check_a_idle("async_rst", 0);
    chk("async_rst_line",  32'(a_ls), 32'd0);
    chk("async_rst_frame", 32'(a_fs), 32'd0);
    step();
    check_a_idle("held_rst", 0);
    rst_a = 1'b0;
    step();
    check_a(0, 0);

    // DUT B: active-high syncs, tick every cycle
    chk("b_rst_hsync",  32'(b_hs), 32'd0);
    chk("b_rst_vsync",  32'(b_vs), 32'd0);
    chk("b_rst_p_tick", 32'(b_pt), 32'd0);
    chk("b_rst_run",    32'(b_run), 32'd0);
    rst_b = 1'b0;
    en_b  = 1'b1;
    for (int n = 0; n <= 50; n++) begin
      step();
      check_b(n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
